// File: rtl/pinc_sweep_ctrl_if.sv
// Control/status bundle between the register block (master) and the sweep controller (slave).
interface pinc_sweep_ctrl_if #(
   parameter int unsigned PW = 32,
   parameter int unsigned DW = 16
);
   logic [PW-1:0] cfg_start_i;
   logic [PW-1:0] cfg_stop_i;
   logic [PW-1:0] cfg_step_i;
   logic [DW-1:0] cfg_dwell_i;
   logic [1:0]    cfg_mode_i;
   logic          start_i;
   logic          abort_i;
   logic [PW-1:0] p_inc_o;
   logic          acc_rst_o;
   logic          step_o;
   logic          busy_o;
   logic          done_o;

   modport master (
      output cfg_start_i, cfg_stop_i, cfg_step_i, cfg_dwell_i, cfg_mode_i, start_i, abort_i,
      input  p_inc_o, acc_rst_o, step_o, busy_o, done_o
   );

   modport slave (
      input  cfg_start_i, cfg_stop_i, cfg_step_i, cfg_dwell_i, cfg_mode_i, start_i, abort_i,
      output p_inc_o, acc_rst_o, step_o, busy_o, done_o
   );
endinterface

// File: rtl/pinc_sweep_ctrl.sv
// Phase-increment sweep sequencer: steps p_inc from start to stop with programmable
// step and dwell, in single, sawtooth or triangle mode; launches the accumulator coherently.
module pinc_sweep_ctrl #(
   parameter int unsigned PW = 32,
   parameter int unsigned DW = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   pinc_sweep_ctrl_if.slave sweep
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
   typedef enum logic [1:0] {M_SINGLE = 2'b00, M_SAW = 2'b01, M_TRI = 2'b10, M_SINGLE_ALT = 2'b11} mode_e;

   state_e        state;
   mode_e         sh_mode;
   logic [PW-1:0] sh_start;
   logic [PW-1:0] sh_stop;
   logic [PW-1:0] sh_step;
   logic [DW-1:0] sh_dwell_m1;
   logic [PW-1:0] target;
   logic [DW-1:0] cnt;
   logic [PW-1:0] p_inc_q;
   logic          acc_rst_q;
   logic          step_q;
   logic          busy_q;
   logic          done_q;

   logic          at_end;
   logic          is_single;
   logic [PW-1:0] new_target;
   logic [PW-1:0] nxt;
   logic [DW-1:0] cfg_dwell_m1;

   // Move one step toward tgt in PW+1 bits; overshoot or carry/borrow clamps to tgt.
   function automatic logic [PW-1:0] step_toward(input logic [PW-1:0] cur,
                                                 input logic [PW-1:0] tgt,
                                                 input logic [PW-1:0] stp);
      logic [PW:0] sum;
      logic [PW:0] diff;
      sum  = {1'b0, cur} + {1'b0, stp};
      diff = {1'b0, cur} - {1'b0, stp};
      if (tgt >= cur)
         step_toward = (sum > {1'b0, tgt}) ? tgt : sum[PW-1:0];
      else
         step_toward = (diff[PW] || (diff[PW-1:0] < tgt)) ? tgt : diff[PW-1:0];
   endfunction

   assign cfg_dwell_m1 = (sweep.cfg_dwell_i == '0) ? '0 : sweep.cfg_dwell_i - 1'b1;
   assign is_single    = (sh_mode != M_SAW) && (sh_mode != M_TRI);

   // A zero step can never reach the target, so it is treated as already there.
   always_comb begin
      at_end     = (p_inc_q == target) || (sh_step == '0);
      new_target = target;
      nxt        = p_inc_q;
      if (!at_end) begin
         nxt = step_toward(p_inc_q, target, sh_step);
      end else begin
         case (sh_mode)
            M_SAW: nxt = sh_start;
            M_TRI: begin
               new_target = (target == sh_stop) ? sh_start : sh_stop;
               nxt        = step_toward(p_inc_q, new_target, sh_step);
            end
            default: nxt = p_inc_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         sh_mode     <= M_SINGLE;
         sh_start    <= '0;
         sh_stop     <= '0;
         sh_step     <= '0;
         sh_dwell_m1 <= '0;
         target      <= '0;
         cnt         <= '0;
         p_inc_q     <= '0;
         acc_rst_q   <= 1'b0;
         step_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         acc_rst_q <= 1'b0;
         step_q    <= 1'b0;
         done_q    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (sweep.start_i && !sweep.abort_i) begin
                  sh_mode     <= mode_e'(sweep.cfg_mode_i);
                  sh_start    <= sweep.cfg_start_i;
                  sh_stop     <= sweep.cfg_stop_i;
                  sh_step     <= sweep.cfg_step_i;
                  sh_dwell_m1 <= cfg_dwell_m1;
                  target      <= sweep.cfg_stop_i;
                  cnt         <= cfg_dwell_m1;
                  p_inc_q     <= sweep.cfg_start_i;
                  acc_rst_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  state       <= S_RUN;
               end
            end
            S_RUN: begin
               if (sweep.abort_i) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt     <= sh_dwell_m1;
                  target  <= new_target;
                  p_inc_q <= nxt;
                  step_q  <= (nxt != p_inc_q);
                  if (at_end && is_single) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= S_DONE;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign sweep.p_inc_o   = p_inc_q;
   assign sweep.acc_rst_o = acc_rst_q;
   assign sweep.step_o    = step_q;
   assign sweep.busy_o    = busy_q;
   assign sweep.done_o    = done_q;

endmodule

// File: tb/tb_pinc_sweep_ctrl.sv
// Directed bench for pinc_sweep_ctrl: a vector table for the basic sweep plus
// hand-written sequences for clamping, modes, abort, reset and shadowing.
module tb_pinc_sweep_ctrl;

   localparam logic [3:0] F_IDLE = 4'b0000;  // {acc_rst, step, busy, done}
   localparam logic [3:0] F_RST  = 4'b1010;
   localparam logic [3:0] F_STEP = 4'b0110;
   localparam logic [3:0] F_BUSY = 4'b0010;
   localparam logic [3:0] F_DONE = 4'b0001;

   typedef struct {
      logic        start;
      logic        abort;
      logic [31:0] exp_p;
      logic [3:0]  exp_f;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   vec_t tbl [15];

   pinc_sweep_ctrl_if #(.PW(32), .DW(16)) sif ();

   pinc_sweep_ctrl #(.PW(32), .DW(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .sweep (sif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] ep, input logic [3:0] ef);
      logic [3:0] af;
      af = {sif.acc_rst_o, sif.step_o, sif.busy_o, sif.done_o};
      n_cmp++;
      if ((sif.p_inc_o !== ep) || (af !== ef)) begin
         n_err++;
         $display("FAIL %s: p_inc=%h flags=%b expected p_inc=%h flags=%b", nm, sif.p_inc_o, af, ep, ef);
      end
   endtask

   task automatic ex(input string nm, input logic [31:0] ep, input logic [3:0] ef);
      chk(nm, ep, ef);
      @(negedge clk);
   endtask

   task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                      input logic [15:0] d, input logic [1:0] m);
      sif.cfg_start_i = s;
      sif.cfg_stop_i  = e;
      sif.cfg_step_i  = st;
      sif.cfg_dwell_i = d;
      sif.cfg_mode_i  = m;
   endtask

   task automatic launch();
      sif.start_i = 1'b1;
      @(negedge clk);
      sif.start_i = 1'b0;
   endtask

   task automatic set_row(input int i, input logic s, input logic a, input logic [31:0] p, input logic [3:0] f);
      tbl[i].start = s;
      tbl[i].abort = a;
      tbl[i].exp_p = p;
      tbl[i].exp_f = f;
   endtask

   initial begin
      // Basic single sweep 100..130 step 10 dwell 3; row 5 re-pulses start_i, which must be ignored.
      set_row(0,  1'b1, 1'b0, 32'd0,   F_IDLE);
      set_row(1,  1'b0, 1'b0, 32'd100, F_RST);
      set_row(2,  1'b0, 1'b0, 32'd100, F_BUSY);
      set_row(3,  1'b0, 1'b0, 32'd100, F_BUSY);
      set_row(4,  1'b0, 1'b0, 32'd110, F_STEP);
      set_row(5,  1'b1, 1'b0, 32'd110, F_BUSY);
      set_row(6,  1'b0, 1'b0, 32'd110, F_BUSY);
      set_row(7,  1'b0, 1'b0, 32'd120, F_STEP);
      set_row(8,  1'b0, 1'b0, 32'd120, F_BUSY);
      set_row(9,  1'b0, 1'b0, 32'd120, F_BUSY);
      set_row(10, 1'b0, 1'b0, 32'd130, F_STEP);
      set_row(11, 1'b0, 1'b0, 32'd130, F_BUSY);
      set_row(12, 1'b0, 1'b0, 32'd130, F_BUSY);
      set_row(13, 1'b0, 1'b0, 32'd130, F_DONE);
      set_row(14, 1'b0, 1'b0, 32'd130, F_IDLE);

      sif.start_i = 1'b0;
      sif.abort_i = 1'b0;
      cfg(32'd100, 32'd130, 32'd10, 16'd3, 2'b00);
      repeat (2) @(negedge clk);
      chk("reset_held", 32'd0, F_IDLE);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_released", 32'd0, F_IDLE);

      for (int i = 0; i < 15; i++) begin
         chk($sformatf("tbl_row%0d", i), tbl[i].exp_p, tbl[i].exp_f);
         sif.start_i = tbl[i].start;
         sif.abort_i = tbl[i].abort;
         @(negedge clk);
      end
      sif.start_i = 1'b0;
      sif.abort_i = 1'b0;

      cfg(32'd0, 32'd25, 32'd10, 16'd1, 2'b00);
      launch();
      ex("clamp_0", 32'd0, F_RST);
      ex("clamp_10", 32'd10, F_STEP);
      ex("clamp_20", 32'd20, F_STEP);
      ex("clamp_25", 32'd25, F_STEP);
      ex("clamp_done", 32'd25, F_DONE);
      ex("clamp_idle", 32'd25, F_IDLE);

      cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2'b11);
      launch();
      ex("ovf_start", 32'hFFFF_FFF0, F_RST);
      ex("ovf_clamp", 32'hFFFF_FFFF, F_STEP);
      ex("ovf_done", 32'hFFFF_FFFF, F_DONE);

      // Down sweep with dwell 0; cfg is scrambled after launch and must not matter.
      cfg(32'h40, 32'h10, 32'h18, 16'd0, 2'b00);
      launch();
      cfg(32'h0, 32'h30, 32'h1, 16'd5, 2'b01);
      ex("down_40", 32'h40, F_RST);
      ex("down_28", 32'h28, F_STEP);
      ex("down_10", 32'h10, F_STEP);
      ex("down_done", 32'h10, F_DONE);

      cfg(32'd50, 32'd90, 32'd0, 16'd2, 2'b00);
      launch();
      ex("step0_a", 32'd50, F_RST);
      ex("step0_b", 32'd50, F_BUSY);
      ex("step0_done", 32'd50, F_DONE);

      cfg(32'd10, 32'd30, 32'd10, 16'd2, 2'b10);
      launch();
      ex("tri_10a", 32'd10, F_RST);
      ex("tri_10b", 32'd10, F_BUSY);
      ex("tri_20a", 32'd20, F_STEP);
      ex("tri_20b", 32'd20, F_BUSY);
      ex("tri_30a", 32'd30, F_STEP);
      ex("tri_30b", 32'd30, F_BUSY);
      ex("tri_20c", 32'd20, F_STEP);
      ex("tri_20d", 32'd20, F_BUSY);
      ex("tri_10c", 32'd10, F_STEP);
      ex("tri_10d", 32'd10, F_BUSY);
      ex("tri_20e", 32'd20, F_STEP);
      chk("tri_20f", 32'd20, F_BUSY);
      sif.abort_i = 1'b1;
      @(negedge clk);
      sif.abort_i = 1'b0;
      ex("tri_abort", 32'd20, F_IDLE);

      cfg(32'd5, 32'd7, 32'd1, 16'd1, 2'b01);
      launch();
      ex("saw_5a", 32'd5, F_RST);
      ex("saw_6a", 32'd6, F_STEP);
      ex("saw_7a", 32'd7, F_STEP);
      ex("saw_5b", 32'd5, F_STEP);
      ex("saw_6b", 32'd6, F_STEP);
      ex("saw_7b", 32'd7, F_STEP);
      ex("saw_5c", 32'd5, F_STEP);
      chk("saw_6c", 32'd6, F_STEP);
      sif.abort_i = 1'b1;
      @(negedge clk);
      sif.abort_i = 1'b0;
      ex("saw_abort", 32'd6, F_IDLE);

      cfg(32'd100, 32'd130, 32'd10, 16'd3, 2'b00);
      launch();
      ex("ab_100a", 32'd100, F_RST);
      ex("ab_100b", 32'd100, F_BUSY);
      ex("ab_100c", 32'd100, F_BUSY);
      ex("ab_110a", 32'd110, F_STEP);
      ex("ab_110b", 32'd110, F_BUSY);
      ex("ab_110c", 32'd110, F_BUSY);
      chk("ab_120", 32'd120, F_STEP);
      sif.abort_i = 1'b1;
      @(negedge clk);
      sif.abort_i = 1'b0;
      ex("ab_idle", 32'd120, F_IDLE);
      ex("ab_no_done", 32'd120, F_IDLE);

      sif.start_i = 1'b1;
      sif.abort_i = 1'b1;
      @(negedge clk);
      sif.start_i = 1'b0;
      sif.abort_i = 1'b0;
      ex("abort_start_idle_a", 32'd120, F_IDLE);
      ex("abort_start_idle_b", 32'd120, F_IDLE);

      launch();
      ex("rst_mid_100a", 32'd100, F_RST);
      ex("rst_mid_100b", 32'd100, F_BUSY);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ex("rst_mid_clear", 32'd0, F_IDLE);
      ex("rst_mid_stay", 32'd0, F_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
